mem_stage_ctrl: RTL and testbench

Memory-stage consumer of the EX/MEM pipeline register in the 16-bit core. It takes the registered EX/MEM fields and either passes ALU/PC+2 results straight to writeback, or runs a handshaked load/store against a variable-latency data memory. While an access is in flight it stalls the upstream register. It produces the registered writeback fields (MEM/WB boundary) consumed by the register file.

---
 rtl/mem_stage_ctrl.sv | 160 ++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory stage of the 16-bit core: forwards ALU/PC+2 results to writeback or
// performs a handshaked load/store, stalling the EX/MEM register meanwhile.
module mem_stage_ctrl #(
  parameter int DATA_W  = 16,
  parameter int RD_W    = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              IRegWrite,
  input  logic              IMemWrite,
  input  logic              IMemRead,
  input  logic [1:0]        IRegStore,
  input  logic [DATA_W-1:0] IPCP2,
  input  logic [DATA_W-1:0] IALUResult,
  input  logic [DATA_W-1:0] I3rdArg,
  input  logic [RD_W-1:0]   IRd,
  output logic              Stall,
  output logic              MemReq,
  output logic              MemWe,
  output logic [DATA_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWData,
  input  logic [DATA_W-1:0] MemRData,
  input  logic              MemReady,
  output logic              WBRegWrite,
  output logic [RD_W-1:0]   WBRd,
  output logic [DATA_W-1:0] WBData,
  output logic              MemErr
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t              state_reg, state_next;
  logic [7:0]          cnt_reg, cnt_next;
  logic [DATA_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W-1:0]   pcp2_reg, pcp2_next;
  logic [RD_W-1:0]     rd_reg, rd_next;
  logic                regwrite_reg, regwrite_next;
  logic [1:0]          regstore_reg, regstore_next;
  logic                we_reg, we_next;
  logic                wb_regwrite_reg, wb_regwrite_next;
  logic [RD_W-1:0]     wb_rd_reg, wb_rd_next;
  logic [DATA_W-1:0]   wb_data_reg, wb_data_next;
  logic                err_reg, err_next;

  // Source 01 selects memory data, which is only available on a completed load.
  function automatic logic [DATA_W-1:0] sel(input logic [1:0] src,
                                            input logic [DATA_W-1:0] alu,
                                            input logic [DATA_W-1:0] pcp2);
    case (src)
      2'b01:   sel = '0;
      2'b10:   sel = pcp2;
      default: sel = alu;
    endcase
  endfunction

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg       <= IDLE;
      cnt_reg         <= '0;
      addr_reg        <= '0;
      wdata_reg       <= '0;
      pcp2_reg        <= '0;
      rd_reg          <= '0;
      regwrite_reg    <= 1'b0;
      regstore_reg    <= '0;
      we_reg          <= 1'b0;
      wb_regwrite_reg <= 1'b0;
      wb_rd_reg       <= '0;
      wb_data_reg     <= '0;
      err_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      addr_reg        <= addr_next;
      wdata_reg       <= wdata_next;
      pcp2_reg        <= pcp2_next;
      rd_reg          <= rd_next;
      regwrite_reg    <= regwrite_next;
      regstore_reg    <= regstore_next;
      we_reg          <= we_next;
      wb_regwrite_reg <= wb_regwrite_next;
      wb_rd_reg       <= wb_rd_next;
      wb_data_reg     <= wb_data_next;
      err_reg         <= err_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    addr_next        = addr_reg;
    wdata_next       = wdata_reg;
    pcp2_next        = pcp2_reg;
    rd_next          = rd_reg;
    regwrite_next    = regwrite_reg;
    regstore_next    = regstore_reg;
    we_next          = we_reg;
    wb_regwrite_next = wb_regwrite_reg;
    wb_rd_next       = wb_rd_reg;
    wb_data_next     = wb_data_reg;
    err_next         = err_reg;
    Stall            = 1'b0;
    MemReq           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (IMemRead || IMemWrite) begin
          Stall            = 1'b1;
          addr_next        = IALUResult;
          wdata_next       = I3rdArg;
          pcp2_next        = IPCP2;
          rd_next          = IRd;
          regwrite_next    = IRegWrite;
          regstore_next    = IRegStore;
          we_next          = IMemWrite;
          cnt_next         = '0;
          wb_regwrite_next = 1'b0;
          state_next       = ACCESS;
        end else begin
          wb_regwrite_next = IRegWrite;
          wb_rd_next       = IRd;
          wb_data_next     = sel(IRegStore, IALUResult, IPCP2);
        end
      end
      ACCESS: begin
        MemReq = 1'b1;
        if (MemReady) begin
          state_next       = IDLE;
          wb_regwrite_next = regwrite_reg;
          wb_rd_next       = rd_reg;
          wb_data_next     = (!we_reg && regstore_reg == 2'b01) ? MemRData
                                                                : sel(regstore_reg, addr_reg, pcp2_reg);
        end else if (cnt_reg == CNT_LAST) begin
          // Abort releases the pipeline; the instruction is dropped.
          state_next       = IDLE;
          err_next         = 1'b1;
          wb_regwrite_next = 1'b0;
        end else begin
          Stall            = 1'b1;
          cnt_next         = cnt_reg + 8'd1;
          wb_regwrite_next = 1'b0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign MemWe      = we_reg;
  assign MemAddr    = addr_reg;
  assign MemWData   = wdata_reg;
  assign WBRegWrite = wb_regwrite_reg;
  assign WBRd       = wb_rd_reg;
  assign WBData     = wb_data_reg;
  assign MemErr     = err_reg;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed plus random transactions against a per-instruction reference model
// of the memory stage (latency, stall length, writeback value, sticky error).
module tb_mem_stage_ctrl;
  localparam int DW = 16;
  localparam int RW = 3;
  localparam int TO = 4;

  logic          CLK = 1'b0;
  logic          Reset;
  logic          IRegWrite, IMemWrite, IMemRead;
  logic [1:0]    IRegStore;
  logic [DW-1:0] IPCP2, IALUResult, I3rdArg;
  logic [RW-1:0] IRd;
  logic          Stall, MemReq, MemWe;
  logic [DW-1:0] MemAddr, MemWData, MemRData;
  logic          MemReady;
  logic          WBRegWrite;
  logic [RW-1:0] WBRd;
  logic [DW-1:0] WBData;
  logic          MemErr;

  int n_checks = 0;
  int n_fails  = 0;

  // Model of architecturally visible writeback state
  logic          m_wbrw;
  logic [RW-1:0] m_rd;
  logic [DW-1:0] m_data;
  logic          m_err;

  mem_stage_ctrl #(.DATA_W(DW), .RD_W(RW), .TIMEOUT(TO)) dut (
    .CLK(CLK), .Reset(Reset),
    .IRegWrite(IRegWrite), .IMemWrite(IMemWrite), .IMemRead(IMemRead),
    .IRegStore(IRegStore), .IPCP2(IPCP2), .IALUResult(IALUResult),
    .I3rdArg(I3rdArg), .IRd(IRd),
    .Stall(Stall), .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRData(MemRData), .MemReady(MemReady),
    .WBRegWrite(WBRegWrite), .WBRd(WBRd), .WBData(WBData), .MemErr(MemErr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] pick(input logic [1:0] rs, input logic [DW-1:0] alu,
                                         input logic [DW-1:0] pcp2);
    if (rs == 2'b10) return pcp2;
    if (rs == 2'b01) return '0;
    return alu;
  endfunction

  task automatic check_wb(input string tag);
    check({tag, "_wbrw"},  32'(WBRegWrite), 32'(m_wbrw));
    check({tag, "_wbrd"},  32'(WBRd),       32'(m_rd));
    check({tag, "_wbdata"}, 32'(WBData),    32'(m_data));
    check({tag, "_err"},   32'(MemErr),     32'(m_err));
    check({tag, "_req_idle"}, 32'(MemReq),  32'd0);
  endtask

  // Called at a negedge; returns at the negedge after writeback.
  task automatic alu_op(input logic rw, input logic [1:0] rs, input logic [DW-1:0] pcp2,
                        input logic [DW-1:0] alu, input logic [RW-1:0] rd);
    IRegWrite = rw; IMemWrite = 1'b0; IMemRead = 1'b0; IRegStore = rs;
    IPCP2 = pcp2; IALUResult = alu; I3rdArg = DW'($urandom); IRd = rd; MemReady = 1'b0;
    #1;
    check("alu_stall", 32'(Stall), 32'd0);
    check("alu_req", 32'(MemReq), 32'd0);
    @(posedge CLK); @(negedge CLK);
    m_wbrw = rw; m_rd = rd; m_data = pick(rs, alu, pcp2);
    check_wb("alu_wb");
    $display("alu rw=%0d rs=%0d rd=%0d alu=%h pc2=%h -> wb %0d/%0d/%h",
             rw, rs, rd, alu, pcp2, WBRegWrite, WBRd, WBData);
  endtask

  // lat = ACCESS cycle (1-based) on which MemReady rises; 0 = never.
  task automatic mem_op(input logic rw, input logic wr, input logic rdf, input logic [1:0] rs,
                        input logic [DW-1:0] pcp2, input logic [DW-1:0] alu,
                        input logic [DW-1:0] arg, input logic [RW-1:0] rd,
                        input int lat, input logic [DW-1:0] rdata);
    bit done = 0;
    bit ok;
    int k = 1;
    IRegWrite = rw; IMemWrite = wr; IMemRead = rdf; IRegStore = rs;
    IPCP2 = pcp2; IALUResult = alu; I3rdArg = arg; IRd = rd; MemReady = 1'b0;
    #1;
    check("op_stall", 32'(Stall), 32'd1);
    check("op_req", 32'(MemReq), 32'd0);
    @(posedge CLK);
    while (!done) begin
      @(negedge CLK);
      MemReady = (k == lat);
      MemRData = (k == lat) ? rdata : DW'($urandom);
      #1;
      check("acc_req", 32'(MemReq), 32'd1);
      check("acc_addr", 32'(MemAddr), 32'(alu));
      check("acc_we", 32'(MemWe), 32'(wr));
      if (wr) check("acc_wdata", 32'(MemWData), 32'(arg));
      check("acc_stall", 32'(Stall), 32'((k != lat) && (k != TO)));
      check("acc_bubble", 32'(WBRegWrite), 32'd0);
      if (k == lat || k == TO) done = 1;
      k++;
      @(posedge CLK);
    end
    @(negedge CLK);
    MemReady = 1'b0;
    ok = (lat >= 1 && lat <= TO);
    if (ok) begin
      m_wbrw = rw; m_rd = rd;
      m_data = (!wr && rs == 2'b01) ? rdata : pick(rs, alu, pcp2);
    end else begin
      m_wbrw = 1'b0; m_err = 1'b1;
    end
    check_wb("mem_wb");
    $display("mem we=%0d rd_flag=%0d rs=%0d rd=%0d addr=%h lat=%0d -> wb %0d/%0d/%h err=%0d",
             wr, rdf, rs, rd, alu, lat, WBRegWrite, WBRd, WBData, MemErr);
  endtask

  initial begin
    logic [1:0] code;
    int lat;
    Reset = 1'b1; IRegWrite = 0; IMemWrite = 0; IMemRead = 0; IRegStore = 0;
    IPCP2 = 0; IALUResult = 0; I3rdArg = 0; IRd = 0; MemRData = 0; MemReady = 0;
    m_wbrw = 0; m_rd = 0; m_data = 0; m_err = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    Reset = 1'b0;
    #1;
    check("rst_stall", 32'(Stall), 32'd0);
    check_wb("rst");

    alu_op(1'b1, 2'b00, 16'h0000, 16'h1234, 3'd3);
    alu_op(1'b1, 2'b10, 16'h0042, 16'h9999, 3'd7);
    alu_op(1'b1, 2'b01, 16'h0042, 16'h9999, 3'd5);
    mem_op(1'b1, 1'b0, 1'b1, 2'b01, 16'h0002, 16'h00F0, 16'h0000, 3'd2, 3, 16'hBEEF);
    mem_op(1'b0, 1'b1, 1'b1, 2'b00, 16'h0004, 16'h0010, 16'h5A5A, 3'd4, 2, 16'hDEAD);
    mem_op(1'b1, 1'b0, 1'b1, 2'b01, 16'h0006, 16'h0020, 16'h0000, 3'd6, 0, 16'h0000);
    alu_op(1'b1, 2'b11, 16'h0000, 16'hCAFE, 3'd1);

    // Reset during the second ACCESS cycle while memory signals ready
    IRegWrite = 1; IMemWrite = 0; IMemRead = 1; IRegStore = 2'b01; IALUResult = 16'h0030; IRd = 3'd3;
    @(posedge CLK); @(negedge CLK);
    @(posedge CLK); @(negedge CLK);
    MemReady = 1'b1; MemRData = 16'h1111; Reset = 1'b1;
    @(posedge CLK); @(negedge CLK);
    Reset = 1'b0; MemReady = 1'b0; IMemRead = 0; IRegWrite = 0;
    #1;
    m_wbrw = 0; m_rd = 0; m_data = 0; m_err = 0;
    check("midrst_stall", 32'(Stall), 32'd0);
    check_wb("midrst");
    $display("reset mid-access -> wb %0d/%0d/%h err=%0d req=%0d", WBRegWrite, WBRd, WBData, MemErr, MemReq);
    alu_op(1'b1, 2'b00, 16'h0000, 16'h7777, 3'd2);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        alu_op(1'($urandom), 2'($urandom), DW'($urandom), DW'($urandom), RW'($urandom));
      end else begin
        code = 2'($urandom_range(1, 3));
        lat  = $urandom_range(1, TO + 1);
        if (lat == TO + 1) lat = 0;
        mem_op(1'($urandom), code[1], code[0], 2'($urandom), DW'($urandom), DW'($urandom),
               DW'($urandom), RW'($urandom), lat, DW'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
